coin_dispenser: RTL and testbench



---
 rtl/coin_pkg.sv | 42 ++++
 rtl/coin_timer.sv | 32 +++
 rtl/coin_dispenser.sv | 172 +++++++++++++++++
 tb/tb_coin_dispenser.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coin_pkg
// Purpose  : Shared coin types, coin values, FSM states and datapath widths.
// Revision : 1.0 - initial release
// ============================================================================
package coin_pkg;

    localparam int CNT_W   = 4;
    localparam int CENTS_W = 10;

    localparam logic [CENTS_W-1:0] VAL_Q = 10'd25;
    localparam logic [CENTS_W-1:0] VAL_D = 10'd10;
    localparam logic [CENTS_W-1:0] VAL_N = 10'd5;

    typedef enum logic [1:0] {
        COIN_Q = 2'd0,
        COIN_D = 2'd1,
        COIN_N = 2'd2
    } coin_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    function automatic logic [CENTS_W-1:0] coin_value(input coin_e t);
        logic [CENTS_W-1:0] v;
        case (t)
            COIN_Q:  v = VAL_Q;
            COIN_D:  v = VAL_D;
            COIN_N:  v = VAL_N;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_timer.sv
`default_nettype none
// ============================================================================
// Module   : coin_timer
// Purpose  : Loadable down-counter; tc is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module coin_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : coin_dispenser
// Purpose  : Sequences quarter/dime/nickel eject pulses with fixed gaps and
//            tracks the dispensed value. COIN_DISPENSER_ABORT_EN adds abort.
// Revision : 1.0 - initial release
// ============================================================================
module coin_dispenser #(
    parameter int PULSE_W    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef COIN_DISPENSER_ABORT_EN
    input  logic       abort,
`endif
    input  logic [3:0] quarter,
    input  logic [3:0] dime,
    input  logic [3:0] nickel,
    output logic       eject_quarter,
    output logic       eject_dime,
    output logic       eject_nickel,
    output logic       busy,
    output logic       done,
    output logic [9:0] dispensed_cents
);

    import coin_pkg::*;

    localparam int TMR_MAX = (PULSE_W > GAP_CYCLES) ? PULSE_W : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_W - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

    state_e             r_state, w_nxt_state;
    coin_e              r_type, w_nxt_type, w_sel_type;
    logic [CNT_W-1:0]   r_q, r_d, r_n, w_nxt_q, w_nxt_d, w_nxt_n;
    logic [CENTS_W-1:0] w_nxt_cents;
    logic               w_sel_any;
    logic               r_abort_pend, w_nxt_abort_pend;
    logic               w_abort;
    logic               w_tmr_load, w_tmr_tc;
    logic [TMR_W-1:0]   w_tmr_val;

`ifdef COIN_DISPENSER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    coin_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .tc       (w_tmr_tc)
    );

    // Priority selection of the next coin from the remaining counts.
    always_comb begin
        w_sel_any  = 1'b1;
        w_sel_type = COIN_Q;
        if (r_q != '0) begin
            w_sel_type = COIN_Q;
        end else if (r_d != '0) begin
            w_sel_type = COIN_D;
        end else if (r_n != '0) begin
            w_sel_type = COIN_N;
        end else begin
            w_sel_any = 1'b0;
        end
    end

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_type       = r_type;
        w_nxt_q          = r_q;
        w_nxt_d          = r_d;
        w_nxt_n          = r_n;
        w_nxt_cents      = dispensed_cents;
        w_nxt_abort_pend = r_abort_pend;
        w_tmr_load       = 1'b0;
        w_tmr_val        = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_q     = quarter;
                    w_nxt_d     = dime;
                    w_nxt_n     = nickel;
                    w_nxt_cents = '0;
                    w_nxt_state = S_SELECT;
                end
            end
            S_SELECT, S_GAP: begin
                // The final gap cycle makes the selection itself so the
                // coin-to-coin period is exactly PULSE_W + GAP_CYCLES.
                if (w_abort) begin
                    w_nxt_state = S_DONE;
                end else if (r_state == S_SELECT || w_tmr_tc) begin
                    if (w_sel_any) begin
                        w_nxt_state = S_PULSE;
                        w_nxt_type  = w_sel_type;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = PULSE_LOAD;
                    end else begin
                        w_nxt_state = S_DONE;
                    end
                end
            end
            S_PULSE: begin
                if (w_abort) begin
                    w_nxt_abort_pend = 1'b1;
                end
                if (w_tmr_tc) begin
                    case (r_type)
                        COIN_Q:  w_nxt_q = r_q - 4'd1;
                        COIN_D:  w_nxt_d = r_d - 4'd1;
                        default: w_nxt_n = r_n - 4'd1;
                    endcase
                    w_nxt_cents      = dispensed_cents + coin_value(r_type);
                    w_nxt_abort_pend = 1'b0;
                    if (r_abort_pend || w_abort) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_state = S_GAP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = GAP_LOAD;
                    end
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_type          <= COIN_Q;
            r_q             <= '0;
            r_d             <= '0;
            r_n             <= '0;
            r_abort_pend    <= 1'b0;
            eject_quarter   <= 1'b0;
            eject_dime      <= 1'b0;
            eject_nickel    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            dispensed_cents <= '0;
        end else begin
            r_state         <= w_nxt_state;
            r_type          <= w_nxt_type;
            r_q             <= w_nxt_q;
            r_d             <= w_nxt_d;
            r_n             <= w_nxt_n;
            r_abort_pend    <= w_nxt_abort_pend;
            eject_quarter   <= (w_nxt_state == S_PULSE) && (w_nxt_type == COIN_Q);
            eject_dime      <= (w_nxt_state == S_PULSE) && (w_nxt_type == COIN_D);
            eject_nickel    <= (w_nxt_state == S_PULSE) && (w_nxt_type == COIN_N);
            busy            <= (w_nxt_state != S_IDLE);
            done            <= (w_nxt_state == S_DONE);
            dispensed_cents <= w_nxt_cents;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_dispenser
// Purpose  : Self-checking bench for coin_dispenser (COIN_DISPENSER_ABORT_EN
//            enables the abort sequence).
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_dispenser;

    localparam int PULSE_W    = 2;
    localparam int GAP_CYCLES = 4;
    localparam int PERIOD     = PULSE_W + GAP_CYCLES;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
`ifdef COIN_DISPENSER_ABORT_EN
    logic       abort;
`endif
    logic [3:0] quarter, dime, nickel;
    logic       eject_quarter, eject_dime, eject_nickel;
    logic       busy, done;
    logic [9:0] dispensed_cents;

    always #5 clk = ~clk;

    coin_dispenser #(.PULSE_W(PULSE_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
`ifdef COIN_DISPENSER_ABORT_EN
        .abort           (abort),
`endif
        .quarter         (quarter),
        .dime            (dime),
        .nickel          (nickel),
        .eject_quarter   (eject_quarter),
        .eject_dime      (eject_dime),
        .eject_nickel    (eject_nickel),
        .busy            (busy),
        .done            (done),
        .dispensed_cents (dispensed_cents)
    );

    typedef struct {
        int q;
        int d;
        int n;
        int cents;
        int done_cyc;
        bit disturb;
    } vec_t;

    typedef struct {
        int cents;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Expected {quarter,dime,nickel} eject pattern at cycle c after the start edge.
    function automatic logic [2:0] model_eject(input int q, input int d, input int n, input int c);
        int k, ph;
        if (c < 2) return 3'b000;
        k  = (c - 2) / PERIOD;
        ph = (c - 2) % PERIOD;
        if (k >= q + d + n || ph >= PULSE_W) return 3'b000;
        if (k < q)     return 3'b100;
        if (k < q + d) return 3'b010;
        return 3'b001;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        @(negedge clk);
        quarter = 4'(v.q);
        dime    = 4'(v.d);
        nickel  = 4'(v.n);
        start   = 1'b1;
        e.cents    = v.cents;
        e.done_cyc = v.done_cyc;
        sb.push_back(e);
        @(posedge clk);
        for (int c = 1; c <= v.done_cyc + 1; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (v.disturb && c == 5) begin
                start = 1'b1; quarter = 4'd15; dime = 4'd15; nickel = 4'd15;
            end
            if (v.disturb && c == 6) start = 1'b0;
            check($sformatf("eject c%0d", c), {eject_quarter, eject_dime, eject_nickel},
                  model_eject(v.q, v.d, v.n, c));
            check($sformatf("busy c%0d", c), busy, (c <= v.done_cyc));
            check($sformatf("done c%0d", c), done, (c == v.done_cyc));
            if (c == 1) check("cents cleared", dispensed_cents, 0);
            if (c == v.done_cyc + 1) check("cents hold", dispensed_cents, v.cents);
            if (done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected actual=1 expected=0");
                end else begin
                    e = sb.pop_front();
                    check("done cycle", c, e.done_cyc);
                    check("cents at done", dispensed_cents, e.cents);
                end
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=0 expected=1");
            sb.delete();
        end
    endtask

    initial begin
        vecs[0] = '{3, 1, 1, 90, 32, 1'b0};
        vecs[1] = '{0, 0, 0, 0, 2, 1'b0};
        vecs[2] = '{15, 15, 15, 600, 272, 1'b0};
        vecs[3] = '{1, 1, 0, 35, 14, 1'b1};
        vecs[4] = '{0, 2, 3, 35, 32, 1'b0};
        vecs[5] = '{2, 0, 0, 50, 14, 1'b0};

        rst_n = 1'b0; start = 1'b0;
        quarter = '0; dime = '0; nickel = '0;
`ifdef COIN_DISPENSER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset ejects", {eject_quarter, eject_dime, eject_nickel}, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset cents", dispensed_cents, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset during the second quarter pulse must drop everything at once.
        @(negedge clk);
        quarter = 4'd3; dime = 4'd0; nickel = 4'd0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        check("q pulse before reset", eject_quarter, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset ejects", {eject_quarter, eject_dime, eject_nickel}, 0);
        check("async reset busy", busy, 0);
        check("async reset done", done, 0);
        check("async reset cents", dispensed_cents, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{0, 2, 0, 20, 14, 1'b0});

`ifdef COIN_DISPENSER_ABORT_EN
        // Abort raised on the first cycle of the second quarter pulse.
        @(negedge clk);
        quarter = 4'd4; dime = 4'd0; nickel = 4'd0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check($sformatf("abort eject c%0d", c), {eject_quarter, eject_dime, eject_nickel},
                  (c == 2 || c == 3 || c == 8 || c == 9) ? 3'b100 : 3'b000);
            check($sformatf("abort done c%0d", c), done, (c == 10));
            check($sformatf("abort busy c%0d", c), busy, (c <= 10));
            if (c == 10) check("abort cents", dispensed_cents, 50);
            if (c == 8) abort = 1'b1;
            if (c == 9) abort = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
